// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scancode decoder. It tracks make, break, extended and shift
// state, and emits real key presses as sprite character codes through an
// output FIFO that uses a valid/ready handshake.
module ps2_key_decoder #(
    parameter int CHAR_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int REPEAT_EN  = 0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [7:0]        code_in,
    input  logic              code_valid_in,
    output logic [CHAR_W-1:0] char_out,
    output logic              shift_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              overflow_out,
    output logic              shift_held_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t state_q, state_d;
    logic   is_make, is_break, is_ext;

    // Returns {hit, char}. A cleared hit bit means the code is unmapped and must be dropped.
    function automatic logic [6:0] lookup(input logic ext, input logic [7:0] code);
        logic [6:0] r;
        r = 7'd0;
        if (ext) begin
            case (code)
                8'h75: r = {1'b1, 6'd28};
                8'h72: r = {1'b1, 6'd29};
                8'h6B: r = {1'b1, 6'd30};
                8'h74: r = {1'b1, 6'd31};
                default: r = 7'd0;
            endcase
        end else begin
            case (code)
                8'h1C: r = {1'b1, 6'd1};   8'h32: r = {1'b1, 6'd2};
                8'h21: r = {1'b1, 6'd3};   8'h23: r = {1'b1, 6'd4};
                8'h24: r = {1'b1, 6'd5};   8'h2B: r = {1'b1, 6'd6};
                8'h34: r = {1'b1, 6'd7};   8'h33: r = {1'b1, 6'd8};
                8'h43: r = {1'b1, 6'd9};   8'h3B: r = {1'b1, 6'd10};
                8'h42: r = {1'b1, 6'd11};  8'h4B: r = {1'b1, 6'd12};
                8'h3A: r = {1'b1, 6'd13};  8'h31: r = {1'b1, 6'd14};
                8'h44: r = {1'b1, 6'd15};  8'h4D: r = {1'b1, 6'd16};
                8'h15: r = {1'b1, 6'd17};  8'h2D: r = {1'b1, 6'd18};
                8'h1B: r = {1'b1, 6'd19};  8'h2C: r = {1'b1, 6'd20};
                8'h3C: r = {1'b1, 6'd21};  8'h2A: r = {1'b1, 6'd22};
                8'h1D: r = {1'b1, 6'd23};  8'h22: r = {1'b1, 6'd24};
                8'h35: r = {1'b1, 6'd25};  8'h1A: r = {1'b1, 6'd26};
                8'h29: r = {1'b1, 6'd0};   8'h66: r = {1'b1, 6'd27};
                8'h41: r = {1'b1, 6'd32};  8'h49: r = {1'b1, 6'd33};
                8'h16: r = {1'b1, 6'd35};  8'h1E: r = {1'b1, 6'd36};
                8'h26: r = {1'b1, 6'd37};  8'h25: r = {1'b1, 6'd38};
                8'h2E: r = {1'b1, 6'd39};  8'h36: r = {1'b1, 6'd40};
                8'h3D: r = {1'b1, 6'd41};  8'h3E: r = {1'b1, 6'd42};
                8'h46: r = {1'b1, 6'd43};  8'h45: r = {1'b1, 6'd44};
                8'h5A: r = {1'b1, 6'd48};
                default: r = 7'd0;
            endcase
        end
        return r;
    endfunction

    // Prefix FSM next state. This block also classifies the byte that completes a sequence.
    always_comb begin
        state_d  = state_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        is_ext   = 1'b0;
        if (code_valid_in) begin
            case (state_q)
                S_IDLE: begin
                    if (code_in == 8'hF0)      state_d = S_BRK;
                    else if (code_in == 8'hE0) state_d = S_EXT;
                    else                       is_make = 1'b1;
                end
                S_EXT: begin
                    if (code_in == 8'hF0) state_d = S_EXT_BRK;
                    else begin
                        is_make = 1'b1;
                        is_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    is_break = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    is_break = 1'b1;
                    is_ext   = 1'b1;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    logic       lshift_q, rshift_q;
    logic [8:0] last_key_q;
    logic       last_vld_q;
    logic [6:0] lut;
    logic [8:0] key;
    logic       suppress, emit;

    assign key            = {is_ext, code_in};
    assign lut            = lookup(is_ext, code_in);
    assign suppress       = (REPEAT_EN == 0) && last_vld_q && (last_key_q == key);
    assign emit           = is_make && lut[6] && !suppress;
    assign shift_held_out = lshift_q | rshift_q;

    // Update the shift flags and the last-key register for repeat suppression
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            last_key_q <= '0;
            last_vld_q <= 1'b0;
        end else begin
            if (!is_ext && code_in == 8'h12 && (is_make || is_break)) lshift_q <= is_make;
            if (!is_ext && code_in == 8'h59 && (is_make || is_break)) rshift_q <= is_make;
            if (emit) begin
                last_key_q <= key;
                last_vld_q <= 1'b1;
            end else if (is_break && last_key_q == key) begin
                last_vld_q <= 1'b0;
            end
        end
    end

    logic              s1_vld_q, s1_shift_q;
    logic [CHAR_W-1:0] s1_char_q;

    // Lookup pipeline register. It captures the shift state that was held when the make byte arrived.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_vld_q   <= 1'b0;
            s1_char_q  <= '0;
            s1_shift_q <= 1'b0;
        end else begin
            s1_vld_q   <= emit;
            s1_char_q  <= CHAR_W'(lut[5:0]);
            s1_shift_q <= lshift_q | rshift_q;
        end
    end

    logic [CHAR_W:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic            full, pop, do_push, ovf_q;
    logic [CHAR_W:0] head;

    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign valid_out    = (count_q != '0);
    assign pop          = valid_out & ready_in;
    assign do_push      = s1_vld_q && (!full || pop);
    assign head         = mem[rptr_q];
    assign char_out     = valid_out ? head[CHAR_W-1:0] : '0;
    assign shift_out    = valid_out ? head[CHAR_W] : 1'b0;
    assign overflow_out = ovf_q;

    // FIFO storage. Empty slots are never observed, so the storage has no reset.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wptr_q] <= {s1_shift_q, s1_char_q};
    end

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(pop);
            if (s1_vld_q && full && !pop) ovf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: u0 uses the defaults (REPEAT_EN=0, depth 8) and
// u1 uses REPEAT_EN=1 with a 4-entry FIFO.
module tb_ps2_key_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, vld0, vld1, rdy0, rdy1;
    logic [7:0]  code0, code1;
    logic [15:0] char0, char1;
    logic        sh0, sh1, valid0, valid1, ovf0, ovf1, held0, held1;

    ps2_key_decoder u0 (
        .clk_in(clk), .rst_in(rst0), .code_in(code0), .code_valid_in(vld0),
        .char_out(char0), .shift_out(sh0), .valid_out(valid0), .ready_in(rdy0),
        .overflow_out(ovf0), .shift_held_out(held0));

    ps2_key_decoder #(.FIFO_DEPTH(4), .REPEAT_EN(1)) u1 (
        .clk_in(clk), .rst_in(rst1), .code_in(code1), .code_valid_in(vld1),
        .char_out(char1), .shift_out(sh1), .valid_out(valid1), .ready_in(rdy1),
        .overflow_out(ovf1), .shift_held_out(held1));

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] q0[$];
    logic [16:0] q1[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int which, input logic [7:0] b);
        if (which == 0) begin code0 = b; vld0 = 1'b1; end
        else            begin code1 = b; vld1 = 1'b1; end
        @(posedge clk);
        #1;
        vld0 = 1'b0;
        vld1 = 1'b0;
    endtask

    // Monitor: pop the expected entry on every accepted FIFO head
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst0 && valid0 && rdy0) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL u0 unexpected entry: got char %0d shift %0d", char0, sh0);
            end else begin
                e = q0.pop_front();
                if ({sh0, char0} !== e) begin
                    n_err++;
                    $display("FAIL u0 entry: got char %0d shift %0d expected char %0d shift %0d",
                             char0, sh0, e[15:0], e[16]);
                end
            end
        end
        if (!rst1 && valid1 && rdy1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL u1 unexpected entry: got char %0d shift %0d", char1, sh1);
            end else begin
                e = q1.pop_front();
                if ({sh1, char1} !== e) begin
                    n_err++;
                    $display("FAIL u1 entry: got char %0d shift %0d expected char %0d shift %0d",
                             char1, sh1, e[15:0], e[16]);
                end
            end
        end
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; vld0 = 1'b0; vld1 = 1'b0;
        code0 = 8'h00; code1 = 8'h00; rdy0 = 1'b1; rdy1 = 1'b1;
        tick(2);
        chk("reset valid", int'(valid0), 0);
        chk("reset char", int'(char0), 0);
        chk("reset shift", int'(sh0), 0);
        chk("reset ovf", int'(ovf0), 0);
        chk("reset held", int'(held0), 0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick(1);

        // 1: single press; valid_out is high for one cycle, two cycles after the strobe
        q0.push_back({1'b0, 16'd1});
        send(0, 8'h1C);
        chk("t1 valid N+1", int'(valid0), 0);
        tick(1);
        chk("t1 valid N+2", int'(valid0), 1);
        tick(1);
        chk("t1 valid N+3", int'(valid0), 0);
        send(0, 8'hF0); send(0, 8'h1C);

        // 2: shifted press
        send(0, 8'h12);
        chk("t2 held after make", int'(held0), 1);
        q0.push_back({1'b1, 16'd1});
        send(0, 8'h1C); send(0, 8'hF0); send(0, 8'h1C);
        send(0, 8'hF0); send(0, 8'h12);
        chk("t2 held after break", int'(held0), 0);

        // 3: extended up arrow, then an unmapped code, then a plain key proves the FSM is in IDLE
        q0.push_back({1'b0, 16'd28});
        send(0, 8'hE0); send(0, 8'h75);
        send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h75);
        send(0, 8'h0E);
        q0.push_back({1'b0, 16'd1});
        send(0, 8'h1C); send(0, 8'hF0); send(0, 8'h1C);

        // 4: repeat handling on both instances
        q0.push_back({1'b0, 16'd23});
        q0.push_back({1'b0, 16'd23});
        send(0, 8'h1D); send(0, 8'h1D); send(0, 8'h1D);
        send(0, 8'hF0); send(0, 8'h1D); send(0, 8'h1D);
        send(0, 8'hF0); send(0, 8'h1D);
        for (int i = 0; i < 4; i++) q1.push_back({1'b0, 16'd23});
        send(1, 8'h1D); send(1, 8'h1D); send(1, 8'h1D);
        send(1, 8'hF0); send(1, 8'h1D); send(1, 8'h1D);
        send(1, 8'hF0); send(1, 8'h1D);
        tick(4);

        // 5: overflow of the 4-deep FIFO, then drain
        rdy1 = 1'b0;
        begin
            logic [7:0] mk [6];
            mk = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36};
            for (int i = 0; i < 6; i++) begin
                if (i < 4) q1.push_back({1'b0, 16'(35 + i)});
                send(1, mk[i]); send(1, 8'hF0); send(1, mk[i]);
            end
        end
        tick(3);
        chk("t5 overflow", int'(ovf1), 1);
        chk("t5 head stable", int'(char1), 35);
        rdy1 = 1'b1;
        tick(8);
        chk("t5 drained valid", int'(valid1), 0);
        chk("t5 overflow sticky", int'(ovf1), 1);

        // 6a: full FIFO with a simultaneous push and pop
        rst1 = 1'b1; tick(1); rst1 = 1'b0;
        chk("t6 ovf cleared", int'(ovf1), 0);
        rdy1 = 1'b0;
        for (int i = 1; i <= 5; i++) q1.push_back({1'b0, 16'(i)});
        send(1, 8'h1C); send(1, 8'h32); send(1, 8'h21); send(1, 8'h23);
        tick(2);
        chk("t6 full valid", int'(valid1), 1);
        send(1, 8'h24);
        rdy1 = 1'b1;
        tick(1);
        rdy1 = 1'b0;
        chk("t6 no overflow", int'(ovf1), 0);
        chk("t6 new head", int'(char1), 2);
        rdy1 = 1'b1;
        tick(6);
        chk("t6 drained valid", int'(valid1), 0);

        // 6b: a reset after a lone F0 discards the break prefix
        send(0, 8'hF0);
        rst0 = 1'b1; tick(1); rst0 = 1'b0;
        chk("t6 rst valid", int'(valid0), 0);
        chk("t6 rst held", int'(held0), 0);
        q0.push_back({1'b0, 16'd1});
        send(0, 8'h1C); send(0, 8'hF0); send(0, 8'h1C);

        tick(10);
        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
